// File: rtl/ram_arbiter.sv
// ram_arbiter: two requesters share one single-port RAM with registered read.
// A winner is chosen from the sampled requests each cycle. The winner's access
// is driven onto the RAM port from registers in the following cycle, together
// with a one-cycle gnt pulse. A granted read returns rvalid one cycle after that.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN. When it is defined, requester 0
// wins every tie. When it is not defined, ties are resolved by round-robin.
module ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SPACE = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_SPACE-1:0] addr0,
  input  logic [ADDR_SPACE-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_SPACE-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  // A requester whose gnt is high this cycle is still holding req for the
  // access being granted now. It must not be counted as a fresh request.
  logic elig0;
  logic elig1;
  logic pick0;
  logic pick1;

  // One-stage read tracker: the access on the RAM port last cycle was a read.
  // Its data is on ram_q this cycle.
  logic rd_pend_valid;
  logic rd_pend_id;

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Last winner. It resets to 1, so requester 0 takes the first tie.
  logic last_winner;
`endif

  // Eligibility and winner selection for the access issued next cycle.
  always_comb begin
    elig0 = req0 & ~gnt0;
    elig1 = req1 & ~gnt1;
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (elig0 && elig1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      pick0 = 1'b1;
`else
      if (last_winner) pick0 = 1'b1;
      else             pick1 = 1'b1;
`endif
    end else begin
      pick0 = elig0;
      pick1 = elig1;
    end
  end

  // RAM port, grant pulses and read tracking, all registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      ram_wren      <= 1'b0;
      ram_address   <= '0;
      ram_data      <= '0;
      rd_pend_valid <= 1'b0;
      rd_pend_id    <= 1'b0;
    end else begin
      gnt0     <= pick0;
      gnt1     <= pick1;
      ram_wren <= (pick0 & wr0) | (pick1 & wr1);
      // Address and data hold their last values when there is no grant.
      if (pick0) begin
        ram_address <= addr0;
        ram_data    <= wdata0;
      end else if (pick1) begin
        ram_address <= addr1;
        ram_data    <= wdata1;
      end
      rd_pend_valid <= (gnt0 | gnt1) & ~ram_wren;
      rd_pend_id    <= gnt1;
    end
  end

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Track the most recent winner for round-robin tie-breaking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_winner <= 1'b1;
    end else if (pick0 || pick1) begin
      last_winner <= pick1;
    end
  end
`endif

  // Read data passes straight through from the RAM. rvalid marks the cycle
  // in which that data belongs to a requester.
  assign rvalid0 = rd_pend_valid & ~rd_pend_id;
  assign rvalid1 = rd_pend_valid &  rd_pend_id;
  assign rdata0  = ram_q;
  assign rdata1  = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter. It contains a behavioural RAM with registered read.
// Stimulus pushes the expected grants and reads into queues.
// A monitor pops these entries and compares them with the DUT outputs.
// Expectations depend on RAM_ARB_FIXED_PRIO_EN where tie order differs.
module tb_ram_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_wren;
  logic [DW-1:0] rdata0, rdata1, ram_data;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] mem [0:65535];

  typedef struct packed {
    logic          id;
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } gnt_t;
  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } rd_t;

  gnt_t gq[$];
  rd_t  rq[$];
  int   errors = 0;
  int   checks = 0;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Single-port RAM model with registered read.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void exp_gnt(input logic id, input logic w, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d);
    gnt_t g;
    g.id = id; g.wren = w; g.addr = a; g.data = d;
    gq.push_back(g);
  endfunction

  function automatic void exp_rd(input logic id, input logic [DW-1:0] d);
    rd_t r;
    r.id = id; r.data = d;
    rq.push_back(r);
  endfunction

  // Monitor: compares every grant and rvalid against the queued expectations.
  logic prev_rd = 1'b0, prev_rd_id = 1'b0, prev_g0 = 1'b0, prev_g1 = 1'b0;
  always @(negedge clock) begin
    gnt_t    g;
    rd_t     r;
    logic [1:0] exp_rv;
    if (!reset_n) begin
      prev_rd = 1'b0; prev_g0 = 1'b0; prev_g1 = 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
        if (gnt0) check("gnt0_back_to_back", {31'd0, prev_g0}, 32'd0);
        if (gnt1) check("gnt1_back_to_back", {31'd0, prev_g1}, 32'd0);
        if (gq.size() == 0) begin
          check("unexpected_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        end else begin
          g = gq.pop_front();
          check("gnt_id", {31'd0, gnt1}, {31'd0, g.id});
          check("gnt_wren", {31'd0, ram_wren}, {31'd0, g.wren});
          check("gnt_addr", {16'd0, ram_address}, {16'd0, g.addr});
          if (g.wren) check("gnt_wdata", {16'd0, ram_data}, {16'd0, g.data});
        end
      end else begin
        check("idle_wren", {31'd0, ram_wren}, 32'd0);
      end
      if (rvalid0 || rvalid1 || prev_rd) begin
        exp_rv = prev_rd ? (prev_rd_id ? 2'b10 : 2'b01) : 2'b00;
        check("rvalid_timing", {30'd0, rvalid1, rvalid0}, {30'd0, exp_rv});
        if (rvalid0 || rvalid1) begin
          if (rq.size() == 0) begin
            check("unexpected_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
          end else begin
            r = rq.pop_front();
            check("rvalid_id", {31'd0, rvalid1}, {31'd0, r.id});
            check("rdata", {16'd0, rvalid1 ? rdata1 : rdata0}, {16'd0, r.data});
          end
        end
      end
      prev_rd    = (gnt0 | gnt1) & ~ram_wren;
      prev_rd_id = gnt1;
      prev_g0    = gnt0;
      prev_g1    = gnt1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"}, {31'd0, gnt0}, 32'd0);
    check({tag, "_gnt1"}, {31'd0, gnt1}, 32'd0);
    check({tag, "_rvalid0"}, {31'd0, rvalid0}, 32'd0);
    check({tag, "_rvalid1"}, {31'd0, rvalid1}, 32'd0);
    check({tag, "_wren"}, {31'd0, ram_wren}, 32'd0);
    check({tag, "_addr"}, {16'd0, ram_address}, 32'd0);
    check({tag, "_data"}, {16'd0, ram_data}, 32'd0);
  endtask

  // Hold each enabled request until that requester has received n grants.
  task automatic run(input int n0, input int n1);
    int c0 = 0, c1 = 0, cyc = 0, first = -1;
    req0 = (n0 > 0);
    req1 = (n1 > 0);
    while ((req0 || req1) && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
      if ((gnt0 || gnt1) && first < 0) first = cyc;
      if (gnt0) begin c0++; if (c0 >= n0) req0 = 1'b0; end
      if (gnt1) begin c1++; if (c1 >= n1) req1 = 1'b0; end
    end
    if (req0 || req1) begin
      check("grant_timeout", 32'd1, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
    end
    check("grant_latency", first, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(2);
    check_all_zero("reset");
    reset_n = 1'b1;
    idle(2);

    // Write 0xBEEF to 0x0010 from requester 0.
    wr0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
    exp_gnt(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    run(1, 0);
    idle(3);

    // Read back from requester 1.
    wr1 = 1'b0; addr1 = 16'h0010; wdata1 = 16'h5555;
    exp_gnt(1'b1, 1'b0, 16'h0010, 16'h0);
    exp_rd(1'b1, 16'hBEEF);
    run(0, 1);
    idle(3);

    // Seed addresses 1 and 2.
    wr0 = 1'b1; addr0 = 16'h0001; wdata0 = 16'h1111;
    exp_gnt(1'b0, 1'b1, 16'h0001, 16'h1111);
    run(1, 0);
    idle(3);
    wr1 = 1'b1; addr1 = 16'h0002; wdata1 = 16'h2222;
    exp_gnt(1'b1, 1'b1, 16'h0002, 16'h2222);
    run(0, 1);
    idle(3);

    // Both requesters keep reading. Grants alternate, starting with requester 0.
    wr0 = 1'b0; addr0 = 16'h0001; wr1 = 1'b0; addr1 = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      exp_gnt(1'b0, 1'b0, 16'h0001, 16'h0); exp_rd(1'b0, 16'h1111);
      exp_gnt(1'b1, 1'b0, 16'h0002, 16'h0); exp_rd(1'b1, 16'h2222);
    end
    run(3, 3);
    idle(3);

    // Requester 0 writes while requester 1 is idle. Requester 1 presents a
    // write with req low, and that write must be ignored.
    wr0 = 1'b1; addr0 = 16'h0003; wdata0 = 16'h3333;
    wr1 = 1'b1; addr1 = 16'h0003; wdata1 = 16'hDEAD;
    exp_gnt(1'b0, 1'b1, 16'h0003, 16'h3333);
    run(1, 0);
    idle(3);

    // Tie when the last winner was requester 0.
    wr0 = 1'b0; addr0 = 16'h0003; wr1 = 1'b0; addr1 = 16'h0001;
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_gnt(1'b0, 1'b0, 16'h0003, 16'h0); exp_rd(1'b0, 16'h3333);
    exp_gnt(1'b1, 1'b0, 16'h0001, 16'h0); exp_rd(1'b1, 16'h1111);
`else
    exp_gnt(1'b1, 1'b0, 16'h0001, 16'h0); exp_rd(1'b1, 16'h1111);
    exp_gnt(1'b0, 1'b0, 16'h0003, 16'h0); exp_rd(1'b0, 16'h3333);
`endif
    run(1, 1);
    idle(3);

    // The read is granted, then reset cuts it off before its rvalid cycle.
    // No read result is expected.
    wr0 = 1'b0; addr0 = 16'h0010;
    exp_gnt(1'b0, 1'b0, 16'h0010, 16'h0);
    req0 = 1'b1;
    @(posedge clock);
    #1;
    check("rst_case_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    idle(2);
    reset_n = 1'b1;
    idle(3);

    // The first tie after reset goes to requester 0.
    wr0 = 1'b0; addr0 = 16'h0001; wr1 = 1'b0; addr1 = 16'h0002;
    exp_gnt(1'b0, 1'b0, 16'h0001, 16'h0); exp_rd(1'b0, 16'h1111);
    exp_gnt(1'b1, 1'b0, 16'h0002, 16'h0); exp_rd(1'b1, 16'h2222);
    run(1, 1);
    idle(4);

    check("grants_outstanding", gq.size(), 32'd0);
    check("reads_outstanding", rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, word width of the shared single-port RAM.
REQ-002 SHALL provide parameter ADDR_SPACE, default 16, address width of the shared RAM.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
- clock  in  1  single clock; all state on its rising edge
- reset_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  requester 0/1 access request; held high until its gnt pulse
- wr0 / wr1  in  1  1 = write, 0 = read; held with req
- addr0 / addr1  in  ADDR_SPACE  access address; held with req
- wdata0 / wdata1  in  DATA_WIDTH  write data; held with req
- gnt0 / gnt1  out  1  one-cycle pulse; the access is on the RAM port this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdata carries read result
- rdata0 / rdata1  out  DATA_WIDTH  read data, equal to ram_q; meaningful only with rvalid
- ram_address  out  ADDR_SPACE  to RAM address
- ram_data  out  DATA_WIDTH  to RAM write data
- ram_wren  out  1  to RAM write enable
- ram_q  in  DATA_WIDTH  RAM registered read data, valid one clock after address is sampled

Function
REQ-005 SHALL sample req0/req1 in cycle N, choose a winner, and in cycle N+1 drive ram_address, ram_data, ram_wren from registers and pulse the winner's gnt.
REQ-006 SHALL, for a granted read in cycle N+1, pulse the matching rvalid in cycle N+2 with rdataX = ram_q.
REQ-007 SHALL drive ram_wren = 0 in any cycle without a grant; ram_address and ram_data keep their last values.
REQ-008 SHALL exclude a requester from arbitration in the cycle its gnt is high, so a held req is never granted twice for one access.
REQ-009 SHALL keep a one-bit last-winner pointer; when both eligible, grant the requester that is not last-winner (round-robin), then update the pointer.
REQ-010 SHALL, with only one requester eligible, grant it regardless of the pointer; the pointer updates to it.
REQ-011 SHALL allow one grant per cycle at most; gnt0 and gnt1 never high together; rvalid0 and rvalid1 never high together.
REQ-012 SHALL sustain one RAM access per cycle when both requesters keep req high (alternating grants); a single requester gets at most one access every two cycles.
REQ-013 SHALL keep a one-stage read-pending register (valid + requester id) so a read grant in cycle N+1 and a new grant in N+2 overlap correctly.
REQ-014 SHALL produce no rvalid for write grants.
REQ-015 SHALL ignore wr/addr/wdata of a requester whose req is low.

Reset
REQ-016 SHALL on reset_n low, asynchronously force gnt0, gnt1, rvalid0, rvalid1, ram_wren to 0, ram_address and ram_data to 0, read-pending to empty, last-winner to 1 (requester 0 wins first tie).
REQ-017 SHALL discard an in-flight read on reset (no rvalid after release); a write whose grant cycle is cut by reset is not guaranteed to complete.
REQ-018 SHALL begin arbitrating on the first rising clock edge with reset_n high.

Configuration
REQ-019 SHALL, with RAM_ARB_FIXED_PRIO_EN defined, replace round-robin with fixed priority: requester 0 wins every tie, last-winner pointer unused; REQ-008 exclusion still applies.
REQ-020 SHALL, without RAM_ARB_FIXED_PRIO_EN, use the round-robin of REQ-009.

Verification
REQ-021 Reset then req0=1, wr0=1, addr0=0x0010, wdata0=0xBEEF -> gnt0 next cycle with ram_wren=1, ram_address=0x0010, ram_data=0xBEEF; no rvalid0.
REQ-022 After REQ-021, req1=1, wr1=0, addr1=0x0010 -> gnt1 one cycle later, rvalid1 the following cycle with rdata1=0xBEEF.
REQ-023 req0 and req1 both held high, reads, addr 0x0001/0x0002 -> grants gnt0,gnt1,gnt0,... each cycle, rvalid alternates one cycle behind, never double grant.
REQ-024 Same stimulus with RAM_ARB_FIXED_PRIO_EN -> first grant gnt0; gnt1 only in cycles where req0 is excluded by REQ-008.
REQ-025 Read granted, reset_n pulsed low before rvalid cycle -> all outputs 0 immediately, no rvalid after release, first subsequent tie goes to requester 0.
